// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch stage:
// fetch FSM states, queue sizing defaults and the queue entry layout.
package instr_fetch_pkg;

  localparam int IQ_DEPTH_DEF  = 8;
  localparam int IQ_ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } iq_entry_t;

endpackage

// File: rtl/fetch_iq_fifo.sv
// Circular instruction queue with push, pop, flush and occupancy count.
// Storage is not reset; consumers mask the head while empty.
module fetch_iq_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEF,
  parameter int AW    = IQ_ADDR_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  iq_entry_t     wdata,
  output iq_entry_t     head,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  iq_entry_t      mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_push = push && (count != FULL);
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + (AW+1)'(do_push)
                       - (AW+1)'(do_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en && !clear && do_push)
      mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, one-outstanding fetch FSM towards the
// memory controller, and an instruction queue feeding decode.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int          IQ_DEPTH  = IQ_DEPTH_DEF,
  parameter int          IQ_ADDR_W = IQ_ADDR_W_DEF,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        if_read_or_not,
  output logic [31:0] intru_addr,
  input  logic        if_load_done,
  input  logic [31:0] mem_ctrl_instru_to_if,
  input  logic        jump_en,
  input  logic [31:0] jump_pc,
  output logic        iq_valid,
  output logic [31:0] iq_instr,
  output logic [31:0] iq_pc,
  input  logic        iq_pop
);

  localparam logic [IQ_ADDR_W:0] FULL = (IQ_ADDR_W+1)'(IQ_DEPTH);

  fetch_state_e         state;
  fetch_state_e         state_nxt;
  logic [31:0]          pc;
  logic [31:0]          pc_nxt;
  logic [IQ_ADDR_W:0]   count;
  logic [IQ_ADDR_W:0]   cnt_after;
  logic                 push;
  logic                 pop;
  iq_entry_t            head;
  iq_entry_t            wdata;

  assign push = !jump_en && (state == REQ)
                && if_load_done;
  assign pop  = !jump_en && iq_pop && iq_valid;

  assign cnt_after = count + (IQ_ADDR_W+1)'(push)
                           - (IQ_ADDR_W+1)'(pop);

  assign wdata.pc    = pc;
  assign wdata.instr = mem_ctrl_instru_to_if;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (jump_en) begin
      pc_nxt    = jump_pc;
      state_nxt = GAP;
    end else begin
      unique case (state)
        IDLE: if (count < FULL) state_nxt = REQ;
        REQ: begin
          if (if_load_done) begin
            pc_nxt    = pc + 32'd4;
            state_nxt = GAP;
          end
        end
        GAP: state_nxt = (cnt_after < FULL) ? REQ : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else if (rdy_in) begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  fetch_iq_fifo #(
    .DEPTH (IQ_DEPTH),
    .AW    (IQ_ADDR_W)
  ) u_iq (
    .clk   (clk_in),
    .rst_n (rst_in),
    .en    (rdy_in),
    .clear (jump_en),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

  assign if_read_or_not = (state == REQ);
  assign intru_addr     = pc;
  assign iq_valid       = (count != '0);
  assign iq_instr       = iq_valid ? head.instr : 32'h0;
  assign iq_pc          = iq_valid ? head.pc : 32'h0;

endmodule
